// File: rtl/score_recorder_pkg.sv
// Shared definitions for the score note word format, recorder states and field widths.
// The playback decoder imports the same package.
package score_recorder_pkg;

    localparam int unsigned NOTE_W = 4;
    localparam int unsigned BAND_W = 3;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned WORD_W = NOTE_W + BAND_W + LEN_W;
    localparam int unsigned KEY_W  = 12;

    localparam logic [WORD_W-1:0] TERM_WORD = 12'h000;
    localparam logic [LEN_W-1:0]  LEN_MAX   = 5'd31;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [BAND_W-1:0] band;
        logic [LEN_W-1:0]  time_len;
    } note_word_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECORD = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_TERM   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/score_recorder_key.sv
// Priority key encoder: lowest pressed key index + 1, or 0 when no key is down (rest).
module key_encoder
    import score_recorder_pkg::*;
(
    input  logic [KEY_W-1:0]  i_key,
    output logic [NOTE_W-1:0] o_code_c
);

    // Scan from the top so the lowest set index wins.
    always_comb begin
        o_code_c = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (i_key[i]) begin
                o_code_c = NOTE_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/score_recorder.sv
// Records live key/band input as packed note words into score memory,
// closing each score with a terminator word.
module score_recorder
    import score_recorder_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned UNITS_PER_SEC = 16,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DEPTH         = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       i_key,
    input  logic [2:0]        i_band_sel,
    input  logic              i_rec_start,
    input  logic              i_rec_stop,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [11:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [ADDR_W-1:0] o_word_cnt
);

    localparam int unsigned TICK   = CLK_HZ / UNITS_PER_SEC;
    localparam int unsigned TICK_W = (TICK > 1) ? $clog2(TICK) : 1;

    logic [KEY_W-1:0]  r_key_s1, r_key_s2;
    logic [BAND_W-1:0] r_band_s1, r_band_s2;
    state_t            r_state, w_state_nxt;
    logic [TICK_W-1:0] r_tick, w_tick_nxt;
    logic [LEN_W-1:0]  r_units, w_units_nxt;
    logic [NOTE_W-1:0] r_cur_code, w_cur_code_nxt;
    logic [BAND_W-1:0] r_cur_band, w_cur_band_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [11:0]       r_mem_wdata;
    logic              r_busy, r_done, r_overflow;
    logic [ADDR_W-1:0] r_word_cnt;

    logic [NOTE_W-1:0] w_code;
    logic              w_change;
    logic              w_wr;
    logic              w_start;
    logic              w_ovf_set;
    note_word_t        w_word;

    key_encoder u_key_encoder (
        .i_key    (r_key_s2),
        .o_code_c (w_code)
    );

    assign w_change = (w_code != r_cur_code) || (r_band_s2 != r_cur_band);

    // Next-state, segment timing and write decision.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_nxt     = r_tick;
        w_units_nxt    = r_units;
        w_cur_code_nxt = r_cur_code;
        w_cur_band_nxt = r_cur_band;
        w_wr           = 1'b0;
        w_start        = 1'b0;
        w_ovf_set      = 1'b0;
        w_word         = '{note: r_cur_code, band: r_cur_band, time_len: r_units};

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_rec_start) begin
                    w_state_nxt    = ST_RECORD;
                    w_start        = 1'b1;
                    w_cur_code_nxt = w_code;
                    w_cur_band_nxt = r_band_s2;
                    w_tick_nxt     = '0;
                    w_units_nxt    = '0;
                end
            end
            ST_RECORD: begin
                if (i_rec_stop) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_change) begin
                    // Sub-unit segments are dropped; a change also swallows a coincident wrap.
                    w_wr           = (r_units != '0);
                    w_cur_code_nxt = w_code;
                    w_cur_band_nxt = r_band_s2;
                    w_tick_nxt     = '0;
                    w_units_nxt    = '0;
                end else if (r_tick == TICK_W'(TICK - 1)) begin
                    w_tick_nxt = '0;
                    if (r_units == LEN_MAX) begin
                        w_wr        = 1'b1;
                        w_units_nxt = LEN_W'(1);
                    end else begin
                        w_units_nxt = r_units + LEN_W'(1);
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
                if (w_wr && (r_addr == ADDR_W'(DEPTH - 2))) begin
                    w_state_nxt = ST_TERM;
                    w_ovf_set   = 1'b1;
                end
            end
            ST_FLUSH: begin
                w_wr        = (r_units != '0);
                w_state_nxt = ST_TERM;
            end
            ST_TERM: begin
                w_wr        = 1'b1;
                w_word      = note_word_t'(TERM_WORD);
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s1    <= '0;
            r_key_s2    <= '0;
            r_band_s1   <= '0;
            r_band_s2   <= '0;
            r_state     <= ST_IDLE;
            r_tick      <= '0;
            r_units     <= '0;
            r_cur_code  <= '0;
            r_cur_band  <= '0;
            r_addr      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_key_s1    <= i_key;
            r_key_s2    <= r_key_s1;
            r_band_s1   <= i_band_sel;
            r_band_s2   <= r_band_s1;
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_units     <= w_units_nxt;
            r_cur_code  <= w_cur_code_nxt;
            r_cur_band  <= w_cur_band_nxt;
            r_mem_we    <= w_wr;
            r_busy      <= (w_state_nxt inside {ST_RECORD, ST_FLUSH, ST_TERM});
            r_done      <= (w_state_nxt == ST_DONE);
            if (w_start) begin
                r_addr     <= '0;
                r_word_cnt <= '0;
                r_overflow <= 1'b0;
            end else if (w_wr) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
                r_addr      <= r_addr + ADDR_W'(1);
                r_word_cnt  <= r_word_cnt + ADDR_W'(1);
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;
    assign o_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_score_recorder.sv
// Bench for score_recorder: a full-depth and a 4-word instance share stimulus and are
// compared every cycle against a segment-level model, plus literal word checks.
module tb_score_recorder;

    localparam int TICK = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] key = '0;
    logic [2:0]  band_sel = '0;
    logic        rec_start = 1'b0;
    logic        rec_stop = 1'b0;

    logic        b_we, b_busy, b_done, b_ovf;
    logic [15:0] b_addr, b_cnt;
    logic [11:0] b_wdata;
    logic        s_we, s_busy, s_done, s_ovf;
    logic [15:0] s_addr, s_cnt;
    logic [11:0] s_wdata;

    score_recorder #(.CLK_HZ(160), .UNITS_PER_SEC(16), .ADDR_W(16), .DEPTH(65536)) u_big (
        .clk(clk), .rst_n(rst_n), .i_key(key), .i_band_sel(band_sel),
        .i_rec_start(rec_start), .i_rec_stop(rec_stop),
        .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
        .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf), .o_word_cnt(b_cnt)
    );

    score_recorder #(.CLK_HZ(160), .UNITS_PER_SEC(16), .ADDR_W(16), .DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .i_key(key), .i_band_sel(band_sel),
        .i_rec_start(rec_start), .i_rec_stop(rec_stop),
        .o_mem_we(s_we), .o_mem_addr(s_addr), .o_mem_wdata(s_wdata),
        .o_busy(s_busy), .o_done(s_done), .o_overflow(s_ovf), .o_word_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    // Model: segments tracked as elapsed cycles and units already written out.
    localparam int PH_IDLE = 0, PH_REC = 1, PH_FLUSH = 2, PH_TERM = 3, PH_DONE = 4;
    int          depth [2] = '{65536, 4};
    int          ph [2], cc [2], cb [2], seg [2], cred [2], na [2], e_cnt [2];
    logic        e_we [2], e_busy [2], e_done [2], e_ovf [2];
    logic [15:0] e_addr [2];
    logic [11:0] e_wdata [2];
    logic [11:0] mk1, mk2;
    logic [2:0]  mb1, mb2;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] dlog [2][8];

    function automatic int code_of(input logic [11:0] k);
        for (int i = 0; i < 12; i++) if (k[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [11:0] mkword(input int n, input int b, input int l);
        return {4'(n), 3'(b), 5'(l)};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ph[m] = PH_IDLE; cc[m] = 0; cb[m] = 0; seg[m] = 0; cred[m] = 0; na[m] = 0;
            e_cnt[m] = 0; e_we[m] = 0; e_busy[m] = 0; e_done[m] = 0; e_ovf[m] = 0;
            e_addr[m] = '0; e_wdata[m] = '0;
        end
        mk1 = '0; mk2 = '0; mb1 = '0; mb2 = '0;
    endtask

    task automatic model_step(input int m);
        int          code, held, nxt;
        logic        wr;
        logic [11:0] word;
        code = code_of(mk2);
        wr   = 1'b0;
        word = '0;
        nxt  = ph[m];
        case (ph[m])
            PH_IDLE, PH_DONE: if (rec_start) begin
                nxt = PH_REC; cc[m] = code; cb[m] = int'(mb2); seg[m] = 0; cred[m] = 0;
                na[m] = 0; e_cnt[m] = 0; e_ovf[m] = 1'b0;
            end
            PH_REC: begin
                if (rec_stop) nxt = PH_FLUSH;
                else if (code != cc[m] || int'(mb2) != cb[m]) begin
                    held = seg[m] / TICK - cred[m];
                    if (held >= 1) begin wr = 1'b1; word = mkword(cc[m], cb[m], held); end
                    cc[m] = code; cb[m] = int'(mb2); seg[m] = 0; cred[m] = 0;
                end else begin
                    seg[m]++;
                    if (seg[m] % TICK == 0 && seg[m] / TICK - cred[m] == 32) begin
                        wr = 1'b1; word = mkword(cc[m], cb[m], 31); cred[m] += 31;
                    end
                end
                if (wr && na[m] == depth[m] - 2) begin nxt = PH_TERM; e_ovf[m] = 1'b1; end
            end
            PH_FLUSH: begin
                held = seg[m] / TICK - cred[m];
                if (held >= 1) begin wr = 1'b1; word = mkword(cc[m], cb[m], held); end
                nxt = PH_TERM;
            end
            PH_TERM: begin wr = 1'b1; word = 12'h000; nxt = PH_DONE; end
            default: nxt = PH_IDLE;
        endcase
        ph[m]   = nxt;
        e_we[m] = wr;
        if (wr) begin
            e_addr[m] = 16'(na[m]); e_wdata[m] = word; na[m]++; e_cnt[m]++;
        end
        e_busy[m] = (nxt == PH_REC || nxt == PH_FLUSH || nxt == PH_TERM);
        e_done[m] = (nxt == PH_DONE);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                for (int m = 0; m < 2; m++) model_step(m);
                mk2 = mk1; mk1 = key; mb2 = mb1; mb1 = band_sel;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic cycle_check();
        logic [47:0] act, req;
        string       nm;
        for (int m = 0; m < 2; m++) begin
            nm  = (m == 0) ? "big" : "small";
            act = (m == 0) ? {b_we, b_addr, b_wdata, b_busy, b_done, b_ovf, b_cnt}
                           : {s_we, s_addr, s_wdata, s_busy, s_done, s_ovf, s_cnt};
            req = {e_we[m], e_addr[m], e_wdata[m], e_busy[m], e_done[m], e_ovf[m], 16'(e_cnt[m])};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL cycle_%s t=%0t actual=%h required=%h", nm, $time, act, req);
            end
        end
        if (b_we && b_addr < 16'd8) dlog[0][b_addr[2:0]] = b_wdata;
        if (s_we && s_addr < 16'd8) dlog[1][s_addr[2:0]] = s_wdata;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            cycle_check();
        end
    endtask

    task automatic clear_log();
        for (int m = 0; m < 2; m++) for (int a = 0; a < 8; a++) dlog[m][a] = 12'hFFF;
    endtask

    task automatic start_pulse();
        rec_start = 1'b1; cyc(1); rec_start = 1'b0;
    endtask

    task automatic stop_pulse();
        rec_stop = 1'b1; cyc(1); rec_stop = 1'b0;
    endtask

    initial begin
        clear_log();
        cyc(2);
        chk("reset_busy", 16'(b_busy), 16'd0);
        chk("reset_done", 16'(b_done), 16'd0);
        chk("reset_we", 16'(s_we), 16'd0);
        chk("reset_cnt", b_cnt, 16'd0);
        #2 rst_n = 1'b1;
        cyc(2);

        // Basic note: 3 units of code 1 then 2 units of rest, band 3.
        band_sel = 3'd3; cyc(4); clear_log();
        key = 12'h001; start_pulse(); cyc(34);
        key = 12'h000; cyc(25);
        stop_pulse(); cyc(6);
        chk("basic_w0", 16'(dlog[0][0]), 16'h163);
        chk("basic_w1", 16'(dlog[0][1]), 16'h062);
        chk("basic_term", 16'(dlog[0][2]), 16'h000);
        chk("basic_cnt", b_cnt, 16'd3);
        chk("basic_done", 16'(b_done), 16'd1);
        chk("basic_ovf", 16'(b_ovf), 16'd0);

        // Long note split at 31 units, band 5.
        band_sel = 3'd5; cyc(4); clear_log();
        key = 12'h010; start_pulse(); cyc(324);
        stop_pulse(); key = 12'h000; cyc(6);
        chk("long_w0", 16'(dlog[0][0]), 16'h5BF);
        chk("long_w1", 16'(dlog[0][1]), 16'h5A1);
        chk("long_term", 16'(dlog[0][2]), 16'h000);

        // Sub-unit glitch inside a rest is discarded and the rest restarts.
        cyc(4); clear_log();
        start_pulse(); cyc(14);
        key = 12'h004; cyc(5);
        key = 12'h000; cyc(25);
        stop_pulse(); cyc(6);
        chk("glitch_w0", 16'(dlog[0][0]), 16'h0A1);
        chk("glitch_w1", 16'(dlog[0][1]), 16'h0A2);
        chk("glitch_term", 16'(dlog[0][2]), 16'h000);
        chk("glitch_cnt", b_cnt, 16'd3);

        // Two keys down: lowest index wins.
        band_sel = 3'd2; key = 12'h0A0; cyc(4); clear_log();
        start_pulse(); cyc(24);
        stop_pulse(); key = 12'h000; cyc(6);
        chk("prio_w0", 16'(dlog[0][0]), 16'h642);
        chk("prio_term", 16'(dlog[0][1]), 16'h000);
        chk("prio_cnt", b_cnt, 16'd2);

        // Three 1-unit notes fill the 4-word memory.
        band_sel = 3'd1; key = 12'h001; cyc(4); clear_log();
        start_pulse(); cyc(11);
        key = 12'h002; cyc(12);
        key = 12'h004; cyc(12);
        key = 12'h000; cyc(14);
        chk("ovf_small_done_early", 16'(s_done), 16'd1);
        stop_pulse(); cyc(6);
        chk("ovf_w0", 16'(dlog[1][0]), 16'h121);
        chk("ovf_w1", 16'(dlog[1][1]), 16'h221);
        chk("ovf_w2", 16'(dlog[1][2]), 16'h321);
        chk("ovf_term", 16'(dlog[1][3]), 16'h000);
        chk("ovf_flag", 16'(s_ovf), 16'd1);
        chk("ovf_done", 16'(s_done), 16'd1);
        chk("ovf_cnt", s_cnt, 16'd4);
        chk("ovf_big_flag", 16'(b_ovf), 16'd0);
        chk("ovf_big_rest", 16'(dlog[0][3]), 16'h021);
        chk("ovf_big_cnt", b_cnt, 16'd5);

        // Reset in the middle of a note, then record again from address 0.
        band_sel = 3'd2; key = 12'h001; cyc(4); clear_log();
        start_pulse(); cyc(14);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", 16'(b_we), 16'd0);
        chk("rst_busy", 16'(b_busy), 16'd0);
        chk("rst_addr", b_addr, 16'd0);
        chk("rst_wdata", 16'(b_wdata), 16'd0);
        chk("rst_cnt", s_cnt, 16'd0);
        chk("rst_ovf", 16'(s_ovf), 16'd0);
        cyc(2);
        #2 rst_n = 1'b1;
        cyc(4); clear_log();
        start_pulse(); cyc(14);
        stop_pulse(); cyc(6);
        chk("rerec_w0", 16'(dlog[0][0]), 16'h141);
        chk("rerec_term", 16'(dlog[0][1]), 16'h000);
        chk("rerec_cnt", b_cnt, 16'd2);
        chk("rerec_small_w0", 16'(dlog[1][0]), 16'h141);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
